step_gen_top: RTL and testbench

//  Top level of the FPGA step generator (Basys 3, 100 MHz). Conditions a noisy external pulse

---
 rtl/step_gen_pkg.sv | 38 +++
 rtl/pulse_conditioner.sv | 48 ++++
 rtl/step_gen_top.sv | 104 ++++++++++
 tb/tb_step_gen_top.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/step_gen_pkg.sv
// Shared constants for the step generator: step index width, filter counter
// width and active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package step_gen_pkg;

   localparam int MAX_STEPS  = 10;
   localparam int STEP_W     = 4;
   localparam int FILT_CNT_W = 4;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Codes above 9 render blank, so 4'hF doubles as the "blank digit" code.
   function automatic logic [6:0] seg_decode(input logic [3:0] i_digit);
      case (i_digit)
         4'd0:    seg_decode = SEG_0;
         4'd1:    seg_decode = SEG_1;
         4'd2:    seg_decode = SEG_2;
         4'd3:    seg_decode = SEG_3;
         4'd4:    seg_decode = SEG_4;
         4'd5:    seg_decode = SEG_5;
         4'd6:    seg_decode = SEG_6;
         4'd7:    seg_decode = SEG_7;
         4'd8:    seg_decode = SEG_8;
         4'd9:    seg_decode = SEG_9;
         default: seg_decode = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/pulse_conditioner.sv
// Synchroniser + consecutive-sample glitch filter + rising-edge strobe for a
// noisy asynchronous input. rst is asynchronous, active-low.
module pulse_conditioner
   import step_gen_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [FILT_CNT_W-1:0]  r_cnt;
   logic                   r_filt;
   logic                   r_filt_d;
   logic                   w_synced;
   logic [FILT_CNT_W-1:0]  w_cnt_inc;

   assign w_synced  = r_sync[SYNC_STAGES-1];
   assign w_cnt_inc = r_cnt + FILT_CNT_W'(1);

   // Any sample agreeing with the filtered level restarts the run count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync   <= '0;
         r_cnt    <= '0;
         r_filt   <= 1'b0;
         r_filt_d <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], din};
         r_filt_d <= r_filt;
         if (w_synced == r_filt) begin
            r_cnt <= '0;
         end else if (w_cnt_inc >= FILT_CNT_W'(FILTER_CYCLES)) begin
            r_filt <= w_synced;
            r_cnt  <= '0;
         end else begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

   assign rise = r_filt & ~r_filt_d;

endmodule

// File: rtl/step_gen_top.sv
// Step generator top: N decode from sw, modulo-N step counter and optional
// seven-segment display (compiled in when STEP_GEN_DISPLAY_EN is defined).
module step_gen_top #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 2,
   parameter int MAX_STEPS     = step_gen_pkg::MAX_STEPS,
   parameter int REFRESH_BITS  = 18
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             pulse_in,
   input  logic [MAX_STEPS-1:0]             sw,
   output logic [3:0]                       an,
   output logic [6:0]                       seg,
   output logic [step_gen_pkg::STEP_W-1:0]  step_out
);

   import step_gen_pkg::*;

   if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || FILTER_CYCLES > 15 ||
       REFRESH_BITS < 2 || MAX_STEPS < 1 || MAX_STEPS > 15) begin : g_param_check
      $error("step_gen_top: parameter out of range");
   end

   logic              w_rise;
   logic [STEP_W-1:0] w_n;
   logic [STEP_W-1:0] r_step;

   pulse_conditioner #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_cond (
      .clk  (clk),
      .rst  (rst),
      .din  (pulse_in),
      .rise (w_rise)
   );

   // Highest set switch wins; no switch set means a single step.
   always_comb begin
      w_n = STEP_W'(1);
      for (int i = 0; i < MAX_STEPS; i++) begin
         if (sw[i]) w_n = STEP_W'(i + 1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_step <= '0;
      end else if (w_rise) begin
         r_step <= (r_step >= w_n - STEP_W'(1)) ? '0 : r_step + STEP_W'(1);
      end else if (r_step >= w_n) begin
         r_step <= '0;
      end
   end

   assign step_out = r_step;

`ifdef STEP_GEN_DISPLAY_EN
   logic [REFRESH_BITS-1:0] r_refresh;
   logic [3:0]              r_an;
   logic [6:0]              r_seg;
   logic [1:0]              w_sel;
   logic [3:0]              w_tens;
   logic [3:0]              w_units;
   logic [3:0]              w_an;
   logic [3:0]              w_digit;

   assign w_sel   = r_refresh[REFRESH_BITS-1 -: 2];
   assign w_tens  = (w_n >= 4'd10) ? 4'd1 : 4'hF;
   assign w_units = (w_n >= 4'd10) ? w_n - 4'd10 : w_n;

   always_comb begin
      w_an    = 4'b1111;
      w_digit = 4'hF;
      case (w_sel)
         2'd3: begin w_an = 4'b0111; w_digit = w_tens;  end
         2'd2: begin w_an = 4'b1011; w_digit = w_units; end
         2'd1: begin w_an = 4'b1101; w_digit = 4'hF;    end
         default: begin w_an = 4'b1110; w_digit = r_step; end
      endcase
   end

   // Outputs are registered so every anode stays dark while in reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_refresh <= '0;
         r_an      <= 4'b1111;
         r_seg     <= SEG_BLANK;
      end else begin
         r_refresh <= r_refresh + REFRESH_BITS'(1);
         r_an      <= w_an;
         r_seg     <= seg_decode(w_digit);
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
`else
   assign an  = 4'b1111;
   assign seg = SEG_BLANK;
`endif

endmodule

// File: tb/tb_step_gen_top.sv
// Directed self-checking bench for step_gen_top (default build, display off).
`timescale 1ns/1ps
module tb_step_gen_top;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pulse_in = 1'b0;
   logic [9:0] sw = 10'd0;
   logic [3:0] an;
   logic [6:0] seg;
   logic [3:0] step_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   step_gen_top dut (
      .clk      (clk),
      .rst      (rst),
      .pulse_in (pulse_in),
      .sw       (sw),
      .an       (an),
      .seg      (seg),
      .step_out (step_out)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Transitions placed 2..4 ns after a falling edge, well clear of rising edges.
   task automatic bouncy_pulse();
      @(negedge clk);
      #2 pulse_in = 1'b1;
      #1 pulse_in = 1'b0;
      #1 pulse_in = 1'b1;
      #1998 pulse_in = 1'b0;
      #1 pulse_in = 1'b1;
      #1 pulse_in = 1'b0;
      #998 pulse_in = 1'b1;   // 10 ns glitch, seen by exactly one rising edge
      #10 pulse_in = 1'b0;
      #990;
   endtask

   task automatic clean_pulse();
      @(negedge clk);
      #2 pulse_in = 1'b1;
      #60 pulse_in = 1'b0;
      #120;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      pulse_in = 1'b0;
      #20 rst = 1'b1;
      #20;
   endtask

   task automatic test_reset();
      #10;
      n_checks++;
      if (step_out !== 4'd0) begin
         n_fail++; $display("FAIL reset_step: step_out=%0d expected 0", step_out);
      end
      n_checks++;
      if (an !== 4'b1111) begin
         n_fail++; $display("FAIL reset_an: an=%b expected 1111", an);
      end
      n_checks++;
      if (seg !== 7'h7F) begin
         n_fail++; $display("FAIL reset_seg: seg=%h expected 7f", seg);
      end
      #10 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (step_out !== 4'd0) begin
         n_fail++; $display("FAIL reset_release: step_out=%0d expected 0", step_out);
      end
   endtask

   task automatic test_latency();
      apply_reset();
      sw = 10'b0000010000;
      @(negedge clk);
      #2 pulse_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (step_out !== 4'd0) begin
         n_fail++; $display("FAIL latency_early: step_out=%0d expected 0 after 4 edges", step_out);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (step_out !== 4'd1) begin
         n_fail++; $display("FAIL latency_5: step_out=%0d expected 1 after 5 edges", step_out);
      end
      @(negedge clk);
      #2 pulse_in = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      n_checks++;
      if (step_out !== 4'd1) begin
         n_fail++; $display("FAIL falling_edge: step_out=%0d expected 1", step_out);
      end
   endtask

   task automatic test_count_n5();
      int exp_v [8] = '{1, 2, 3, 4, 0, 1, 2, 3};
      apply_reset();
      sw = 10'b0000010000;
      for (int i = 0; i < 8; i++) begin
         bouncy_pulse();
         n_checks++;
         if (step_out !== 4'(exp_v[i])) begin
            n_fail++; $display("FAIL n5_pulse%0d: step_out=%0d expected %0d", i, step_out, exp_v[i]);
         end
      end
   endtask

   task automatic test_count_n3();
      int exp_v [6] = '{1, 2, 0, 1, 2, 0};
      apply_reset();
      sw = 10'b0000000110;
      for (int i = 0; i < 6; i++) begin
         bouncy_pulse();
         n_checks++;
         if (step_out !== 4'(exp_v[i])) begin
            n_fail++; $display("FAIL n3_pulse%0d: step_out=%0d expected %0d", i, step_out, exp_v[i]);
         end
      end
   endtask

   task automatic test_count_n10();
      int exp_v [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      apply_reset();
      sw = 10'b1111111111;
      for (int i = 0; i < 12; i++) begin
         bouncy_pulse();
         n_checks++;
         if (step_out !== 4'(exp_v[i])) begin
            n_fail++; $display("FAIL n10_pulse%0d: step_out=%0d expected %0d", i, step_out, exp_v[i]);
         end
      end
   endtask

   task automatic test_n_lowered();
      apply_reset();
      sw = 10'b0000010000;
      repeat (4) clean_pulse();
      n_checks++;
      if (step_out !== 4'd4) begin
         n_fail++; $display("FAIL lower_setup: step_out=%0d expected 4", step_out);
      end
      @(negedge clk);
      sw = 10'b0000000100;
      @(posedge clk);
      #1;
      n_checks++;
      if (step_out !== 4'd0) begin
         n_fail++; $display("FAIL lower_to_n3: step_out=%0d expected 0", step_out);
      end
      @(negedge clk);
      sw = 10'b0000000000;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (step_out !== 4'd0) begin
         n_fail++; $display("FAIL sw_zero_idle: step_out=%0d expected 0", step_out);
      end
      clean_pulse();
      n_checks++;
      if (step_out !== 4'd0) begin
         n_fail++; $display("FAIL sw_zero_pulse: step_out=%0d expected 0", step_out);
      end
   endtask

   task automatic test_reset_mid_pulse();
      apply_reset();
      sw = 10'b0000010000;
      repeat (2) clean_pulse();
      n_checks++;
      if (step_out !== 4'd2) begin
         n_fail++; $display("FAIL mid_setup: step_out=%0d expected 2", step_out);
      end
      @(negedge clk);
      #2 pulse_in = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (step_out !== 4'd0) begin
         n_fail++; $display("FAIL mid_reset: step_out=%0d expected 0", step_out);
      end
      pulse_in = 1'b0;
      #20 rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      n_checks++;
      if (step_out !== 4'd0) begin
         n_fail++; $display("FAIL mid_release: step_out=%0d expected 0", step_out);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_count_n5();
      test_count_n3();
      test_count_n10();
      test_n_lowered();
      test_reset_mid_pulse();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
